// File: rtl/tcb_lite_pkg.sv
// Shared TCB-Lite types: response payload, address-map entry and select-width helper.
package tcb_lite_pkg;

  typedef struct packed {
    logic [31:0] rdt;
    logic [3:0]  sts;
    logic        err;
  } tcb_lite_rsp_t;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] mask;
  } tcb_lite_map_t;

  // Port-select width; a single-bit select is kept even for degenerate maps.
  function automatic int unsigned tcb_lite_sel_width(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tcb_lite_if.sv
// TCB-Lite point-to-point link: valid/ready request handshake plus fixed-delay response.
interface tcb_lite_if #(
    parameter int unsigned ADR = 32,
    parameter int          DLY = 1
);
    import tcb_lite_pkg::*;

    typedef struct packed {
        logic           wen;
        logic [ADR-1:0] adr;
        logic [3:0]     ben;
        logic [31:0]    wdt;
    } req_t;

    logic          vld;
    logic          rdy;
    req_t          req;
    tcb_lite_rsp_t rsp;

    modport man (output vld, req, input rdy, rsp);
    modport sub (input vld, req, output rdy, rsp);

endinterface

// File: rtl/tcb_lite_lib_decoder.sv
// Combinational address decoder: lowest matching map entry wins, otherwise the last port.
module tcb_lite_lib_decoder
    import tcb_lite_pkg::*;
#(
    parameter int          SUB_N = 3,
    parameter int unsigned ADR   = 32,
    parameter int unsigned SW    = tcb_lite_sel_width(SUB_N),
    parameter logic [ADR-1:0] BASE [SUB_N] = '{32'h0000_0000, 32'h0001_0000, 32'h0},
    parameter logic [ADR-1:0] MASK [SUB_N] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'h0}
) (
    input  logic [ADR-1:0] adr_i,
    output logic [SW-1:0]  sel_o,
    output logic           match_o
);

    tcb_lite_map_t ent;

    // Scan from the top down so the lowest matching index overwrites the rest.
    always_comb begin
        sel_o   = SW'(SUB_N - 1);
        match_o = 1'b0;
        ent     = '0;
        for (int i = SUB_N - 2; i >= 0; i--) begin
            ent.base = BASE[i];
            ent.mask = MASK[i];
            if ((adr_i & ent.mask) == (ent.base & ent.mask)) begin
                sel_o   = SW'(i);
                match_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcb_lite_lib_demux.sv
// TCB-Lite demultiplexer: routes requests by address, returns responses from the port
// that accepted the request DLY cycles earlier.
module tcb_lite_lib_demux
    import tcb_lite_pkg::*;
#(
    parameter int          SUB_N = 3,
    parameter int unsigned ADR   = 32,
    parameter int          DLY   = 1,
    parameter logic [ADR-1:0] BASE [SUB_N] = '{32'h0000_0000, 32'h0001_0000, 32'h0},
    parameter logic [ADR-1:0] MASK [SUB_N] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'h0}
) (
    input  logic        clk,
    input  logic        rst,
    tcb_lite_if.sub     man,
    tcb_lite_if.man     sub [SUB_N],
    output logic        miss
);

    localparam int unsigned SW = tcb_lite_sel_width(SUB_N);

    if (SUB_N < 2 || DLY < 0 || DLY > 4) begin : g_param_err
        $fatal(1, "tcb_lite_lib_demux: SUB_N must be >= 2 and DLY in 0..4");
    end

    logic [SW-1:0] sel;
    logic          match;
    logic          trn;
    logic          sub_rdy [SUB_N];
    tcb_lite_rsp_t sub_rsp [SUB_N];

    tcb_lite_lib_decoder #(
        .SUB_N (SUB_N),
        .ADR   (ADR),
        .SW    (SW),
        .BASE  (BASE),
        .MASK  (MASK)
    ) u_decoder (
        .adr_i   (man.req.adr),
        .sel_o   (sel),
        .match_o (match)
    );

    // Interface arrays only take constant indices, so flatten them into local arrays.
    for (genvar i = 0; i < SUB_N; i++) begin : g_port
        assign sub[i].vld = man.vld & (sel == SW'(i));
        assign sub[i].req = man.req;
        assign sub_rdy[i] = sub[i].rdy;
        assign sub_rsp[i] = sub[i].rsp;
    end

    assign man.rdy = sub_rdy[sel];
    assign trn     = man.vld & man.rdy;
    assign miss    = trn & ~match;

    if (DLY == 0) begin : g_comb
        assign man.rsp = trn ? sub_rsp[sel] : '0;
    end else begin : g_track
        typedef struct packed {
            logic          vld;
            logic [SW-1:0] idx;
        } trk_t;

        trk_t trk_q [DLY];

        // Responses are fixed-delay and never stalled, so the pipe shifts unconditionally.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < DLY; k++) trk_q[k] <= '0;
            end else begin
                trk_q[0] <= '{vld: trn, idx: sel};
                for (int k = 1; k < DLY; k++) trk_q[k] <= trk_q[k-1];
            end
        end

        assign man.rsp = trk_q[DLY-1].vld ? sub_rsp[trk_q[DLY-1].idx] : '0;
    end

endmodule
